// File: rtl/gbcore_buffered_if.sv
// Instruction handshake bundle for gbcore_buffered.
// Carries opcode, immediate and valid/ready between source and core.
interface gbcore_buffered_if #(
  parameter int DATA_W = 8
);
  logic [7:0]        instruction;
  logic [DATA_W-1:0] data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output instruction, data, in_valid,
    input  in_ready
  );

  modport slave (
    input  instruction, data, in_valid,
    output in_ready
  );
endinterface

// File: rtl/gbcore_buffered.sv
// Buffered GB-style register/ALU core: instruction FIFO, 8-entry regfile,
// HALT/resume and retired counter. Ports: clock, reset, bus (slave),
// resume, probe {A,B,C,D,E,F,H,L}, halted, retired, fifo_level.
module gbcore_buffered #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  gbcore_buffered_if.slave            bus,
  input  logic                        resume,
  output logic [8*DATA_W-1:0]         probe,
  output logic                        halted,
  output logic [CNT_W-1:0]            retired,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = 8 + DATA_W;

  logic [FW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty, push, pop;

  assign full  = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign bus.in_ready = !full && !reset;
  assign push  = bus.in_valid && bus.in_ready;
  assign pop   = !halted && !empty;

  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= {bus.instruction, bus.data};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // rf[6] holds F; index 6 is never a plain source/destination.
  logic [DATA_W-1:0] rf [8];
  logic [7:0]        op;
  logic [DATA_W-1:0] imm, a, s, res;
  logic              cin, c_use;

  assign {op, imm} = mem[rd_ptr];
  assign a   = rf[7];
  assign s   = (op[2:0] == 3'd6) ? '0 : rf[op[2:0]];
  assign cin = rf[6][DATA_W-4];
  // Only ADC (001) and SBC (011) consume the old carry.
  assign c_use = cin && op[3] && !op[5];

  logic [DATA_W:0] sum, dif;
  logic [4:0]      hsum, hdif;

  assign sum  = {1'b0, a} + {1'b0, s} + (DATA_W+1)'(c_use);
  assign dif  = {1'b0, a} - {1'b0, s} - (DATA_W+1)'(c_use);
  assign hsum = {1'b0, a[3:0]} + {1'b0, s[3:0]} + 5'(c_use);
  assign hdif = {1'b0, a[3:0]} - {1'b0, s[3:0]} - 5'(c_use);

  logic fn, fh, fc;
  logic [DATA_W-1:0] flags;

  always_comb begin
    res = sum[DATA_W-1:0];
    fn  = 1'b0;
    fh  = hsum[4];
    fc  = sum[DATA_W];
    unique case (op[5:3])
      3'd0, 3'd1: ;
      3'd2, 3'd3, 3'd7: begin
        res = dif[DATA_W-1:0];
        fn  = 1'b1;
        fh  = hdif[4];
        fc  = dif[DATA_W];
      end
      3'd4: begin
        res = a & s;
        fh  = 1'b1;
        fc  = 1'b0;
      end
      3'd5: begin
        res = a ^ s;
        fh  = 1'b0;
        fc  = 1'b0;
      end
      3'd6: begin
        res = a | s;
        fh  = 1'b0;
        fc  = 1'b0;
      end
    endcase
  end

  assign flags = {res == '0, fn, fh, fc, {(DATA_W-4){1'b0}}};

  logic is_ldi, is_halt, is_ld, is_alu;

  assign is_halt = op == 8'h76;
  assign is_ldi  = op[7:6] == 2'b00 && op[2:0] == 3'b110
                && op[5:3] != 3'b110;
  assign is_ld   = op[7:6] == 2'b01 && !is_halt;
  assign is_alu  = op[7:6] == 2'b10;

  logic              wr_en, f_en, halt_set;
  logic [2:0]        wr_idx;
  logic [DATA_W-1:0] wr_val;

  always_comb begin
    wr_en    = 1'b0;
    f_en     = 1'b0;
    halt_set = 1'b0;
    wr_idx   = op[5:3];
    wr_val   = res;
    if (pop) begin
      unique case (1'b1)
        is_ldi: begin
          wr_en  = 1'b1;
          wr_val = imm;
        end
        is_halt: halt_set = 1'b1;
        is_ld: begin
          wr_en  = 1'b1;
          wr_val = s;
        end
        is_alu: begin
          wr_en  = op[5:3] != 3'd7;
          wr_idx = 3'd7;
          f_en   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++)
        rf[i] <= (i < 6) ? DATA_W'(i + 1) : '0;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      if (wr_en && wr_idx != 3'd6) rf[wr_idx] <= wr_val;
      if (f_en) rf[6] <= flags;
      if (halt_set) halted <= 1'b1;
      else if (halted && resume) halted <= 1'b0;
      if (pop) retired <= retired + 1'b1;
    end
  end

  assign probe = {rf[7], rf[0], rf[1], rf[2],
                  rf[3], rf[6], rf[4], rf[5]};
  assign fifo_level = count;
endmodule

// File: tb/tb_gbcore_buffered.sv
// Scoreboard bench for gbcore_buffered (8-bit and 16-bit instances).
// Drivers queue expected retire results; monitors compare on each retire.
module tb_gbcore_buffered;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic resume = 1'b0;

  always #5 clock = ~clock;

  gbcore_buffered_if #(.DATA_W(8))  bus8 ();
  gbcore_buffered_if #(.DATA_W(16)) bus16 ();

  logic [63:0]  probe8;
  logic         halted8;
  logic [15:0]  retired8;
  logic [2:0]   level8;
  logic [127:0] probe16;
  logic         halted16;
  logic [2:0]   retired16;
  logic [1:0]   level16;

  gbcore_buffered #(.DATA_W(8), .FIFO_DEPTH(4), .CNT_W(16)) dut8 (
    .clock(clock), .reset(reset), .bus(bus8.slave), .resume(resume),
    .probe(probe8), .halted(halted8), .retired(retired8),
    .fifo_level(level8)
  );

  gbcore_buffered #(.DATA_W(16), .FIFO_DEPTH(2), .CNT_W(3)) dut16 (
    .clock(clock), .reset(reset), .bus(bus16.slave), .resume(1'b0),
    .probe(probe16), .halted(halted16), .retired(retired16),
    .fifo_level(level16)
  );

  typedef struct packed {
    logic [63:0] p;
    logic [15:0] r;
    logic        h;
  } exp8_t;

  typedef struct packed {
    logic [127:0] p;
    logic [2:0]   r;
  } exp16_t;

  exp8_t  q8[$];
  exp16_t q16[$];
  int checks = 0;
  int fails  = 0;

  localparam logic [63:0]  RST8  = 64'h00_01_02_03_04_00_05_06;
  localparam logic [127:0] RST16 =
    128'h0000_0001_0002_0003_0004_0000_0005_0006;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  logic [15:0] last8 = '0;
  logic [2:0]  last16 = '0;

  always @(negedge clock) begin
    exp8_t e;
    if (reset) last8 = retired8;
    else if (retired8 != last8) begin
      last8 = retired8;
      checks++;
      if (q8.size() == 0) begin
        fails++;
        $display("FAIL mon8 unexpected retire: retired=%0d", retired8);
      end else begin
        e = q8.pop_front();
        if (probe8 !== e.p || retired8 !== e.r || halted8 !== e.h) begin
          fails++;
          $display("FAIL mon8 retire: got p=%h r=%0d h=%b want p=%h r=%0d h=%b",
                   probe8, retired8, halted8, e.p, e.r, e.h);
        end
      end
    end
  end

  always @(negedge clock) begin
    exp16_t e;
    if (reset) last16 = retired16;
    else if (retired16 != last16) begin
      last16 = retired16;
      checks++;
      if (q16.size() == 0) begin
        fails++;
        $display("FAIL mon16 unexpected retire: retired=%0d", retired16);
      end else begin
        e = q16.pop_front();
        if (probe16 !== e.p || retired16 !== e.r) begin
          fails++;
          $display("FAIL mon16 retire: got p=%h r=%0d want p=%h r=%0d",
                   probe16, retired16, e.p, e.r);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push8(input logic [7:0] op, input logic [7:0] d,
                       input logic [63:0] p, input logic [15:0] r,
                       input logic h, input bit expect_it);
    int n = 0;
    exp8_t e;
    bus8.instruction = op;
    bus8.data = d;
    bus8.in_valid = 1'b1;
    while (!bus8.in_ready && n < 50) begin
      cyc(1);
      n++;
    end
    if (!bus8.in_ready) begin
      checks++;
      fails++;
      $display("FAIL push8 timeout: in_ready=%b want 1", bus8.in_ready);
    end else begin
      e.p = p;
      e.r = r;
      e.h = h;
      if (expect_it) q8.push_back(e);
      cyc(1);
    end
    bus8.in_valid = 1'b0;
  endtask

  task automatic push16(input logic [7:0] op, input logic [15:0] d,
                        input logic [127:0] p, input logic [2:0] r);
    int n = 0;
    exp16_t e;
    bus16.instruction = op;
    bus16.data = d;
    bus16.in_valid = 1'b1;
    while (!bus16.in_ready && n < 50) begin
      cyc(1);
      n++;
    end
    if (!bus16.in_ready) begin
      checks++;
      fails++;
      $display("FAIL push16 timeout: in_ready=%b want 1", bus16.in_ready);
    end else begin
      e.p = p;
      e.r = r;
      q16.push_back(e);
      cyc(1);
    end
    bus16.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 60) begin
      cyc(1);
      n++;
    end
    chk({nm, " queue drained"}, 128'(q8.size() + q16.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus8.instruction = '0;
    bus8.data = '0;
    bus8.in_valid = 1'b0;
    bus16.instruction = '0;
    bus16.data = '0;
    bus16.in_valid = 1'b0;
    cyc(2);
    chk("in_ready in reset", 128'(bus8.in_ready), 128'd0);
    reset = 1'b0;
    #1;
    chk("reset probe8", 128'(probe8), 128'(RST8));
    chk("reset level8", 128'(level8), 128'd0);
    chk("reset halted8", 128'(halted8), 128'd0);
    chk("reset retired8", 128'(retired8), 128'd0);
    chk("in_ready after reset", 128'(bus8.in_ready), 128'd1);
    chk("reset probe16", probe16, RST16);

    // 16-bit datapath, depth-2 FIFO, 3-bit wrapping counter
    push16(8'h3E, 16'hFFFF,
           128'hFFFF_0001_0002_0003_0004_0000_0005_0006, 3'd1);
    push16(8'h80, 16'h0000,
           128'h0000_0001_0002_0003_0004_B000_0005_0006, 3'd2);
    push16(8'h3E, 16'h0FFF,
           128'h0FFF_0001_0002_0003_0004_B000_0005_0006, 3'd3);
    push16(8'h80, 16'h0000,
           128'h1000_0001_0002_0003_0004_2000_0005_0006, 3'd4);
    for (int i = 5; i < 9; i++)
      push16(8'h00, 16'h0000,
             128'h1000_0001_0002_0003_0004_2000_0005_0006, 3'(i));
    push16(8'h88, 16'h0000,
           128'h1001_0001_0002_0003_0004_0000_0005_0006, 3'd1);
    drain("dut16");
    chk("retired16 wrapped", 128'(retired16), 128'd1);

    // 8-bit core, part one
    push8(8'h80, 8'h00, 64'h01_01_02_03_04_00_05_06, 16'd1, 1'b0, 1);
    push8(8'h3E, 8'hFF, 64'hFF_01_02_03_04_00_05_06, 16'd2, 1'b0, 1);
    push8(8'h80, 8'h00, 64'h00_01_02_03_04_B0_05_06, 16'd3, 1'b0, 1);
    drain("part1");

    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    #1;

    push8(8'h97, 8'h00, 64'h00_01_02_03_04_C0_05_06, 16'd1, 1'b0, 1);
    push8(8'hB8, 8'h00, 64'h00_01_02_03_04_70_05_06, 16'd2, 1'b0, 1);
    push8(8'h41, 8'h00, 64'h00_02_02_03_04_70_05_06, 16'd3, 1'b0, 1);
    push8(8'h67, 8'h00, 64'h00_02_02_03_04_70_00_06, 16'd4, 1'b0, 1);
    push8(8'h7E, 8'h00, 64'h00_02_02_03_04_70_00_06, 16'd5, 1'b0, 1);
    push8(8'h70, 8'h00, 64'h00_02_02_03_04_70_00_06, 16'd6, 1'b0, 1);
    push8(8'h89, 8'h00, 64'h03_02_02_03_04_00_00_06, 16'd7, 1'b0, 1);
    push8(8'h3E, 8'h0F, 64'h0F_02_02_03_04_00_00_06, 16'd8, 1'b0, 1);
    push8(8'h80, 8'h00, 64'h11_02_02_03_04_20_00_06, 16'd9, 1'b0, 1);
    push8(8'hA2, 8'h00, 64'h01_02_02_03_04_20_00_06, 16'd10, 1'b0, 1);
    push8(8'hAB, 8'h00, 64'h05_02_02_03_04_00_00_06, 16'd11, 1'b0, 1);
    push8(8'hB5, 8'h00, 64'h07_02_02_03_04_00_00_06, 16'd12, 1'b0, 1);
    push8(8'h9A, 8'h00, 64'h04_02_02_03_04_40_00_06, 16'd13, 1'b0, 1);
    push8(8'h36, 8'h55, 64'h04_02_02_03_04_40_00_06, 16'd14, 1'b0, 1);
    push8(8'hC3, 8'h00, 64'h04_02_02_03_04_40_00_06, 16'd15, 1'b0, 1);
    push8(8'h3E, 8'h00, 64'h00_02_02_03_04_40_00_06, 16'd16, 1'b0, 1);
    push8(8'hB8, 8'h00, 64'h00_02_02_03_04_70_00_06, 16'd17, 1'b0, 1);
    push8(8'h9A, 8'h00, 64'hFC_02_02_03_04_70_00_06, 16'd18, 1'b0, 1);
    push8(8'h1E, 8'hAA, 64'hFC_02_02_03_AA_70_00_06, 16'd19, 1'b0, 1);
    push8(8'h5B, 8'h00, 64'hFC_02_02_03_AA_70_00_06, 16'd20, 1'b0, 1);

    // HALT, then fill FIFO while halted
    push8(8'h76, 8'h00, 64'hFC_02_02_03_AA_70_00_06, 16'd21, 1'b1, 1);
    for (int i = 0; i < 4; i++)
      push8(8'h00, 8'h00, 64'hFC_02_02_03_AA_70_00_06,
            16'(22 + i), 1'b0, 1);
    chk("halted after HALT", 128'(halted8), 128'd1);
    chk("level full", 128'(level8), 128'd4);
    chk("in_ready when full", 128'(bus8.in_ready), 128'd0);
    bus8.instruction = 8'h00;
    bus8.in_valid = 1'b1;
    cyc(3);
    bus8.in_valid = 1'b0;
    chk("level no overfill", 128'(level8), 128'd4);
    chk("retired while halted", 128'(retired8), 128'd21);
    resume = 1'b1;
    cyc(1);
    resume = 1'b0;
    chk("halted cleared", 128'(halted8), 128'd0);
    chk("no pop on resume edge", 128'(retired8), 128'd21);
    drain("halt");
    chk("level drained", 128'(level8), 128'd0);
    chk("retired after drain", 128'(retired8), 128'd25);

    // Reset with instructions still queued
    push8(8'h76, 8'h00, 64'hFC_02_02_03_AA_70_00_06, 16'd26, 1'b1, 1);
    for (int i = 0; i < 3; i++)
      push8(8'h3E, 8'h99, 64'h0, 16'd0, 1'b0, 0);
    chk("level queued", 128'(level8), 128'd3);
    drain("pre-reset");
    reset = 1'b1;
    #1;
    chk("async reset probe", 128'(probe8), 128'(RST8));
    chk("async reset level", 128'(level8), 128'd0);
    chk("async reset halted", 128'(halted8), 128'd0);
    chk("async reset retired", 128'(retired8), 128'd0);
    chk("in_ready during reset", 128'(bus8.in_ready), 128'd0);
    cyc(1);
    reset = 1'b0;
    cyc(5);
    chk("no stale retire", 128'(retired8), 128'd0);
    chk("no stale probe", 128'(probe8), 128'(RST8));
    push8(8'h80, 8'h00, 64'h01_01_02_03_04_00_05_06, 16'd1, 1'b0, 1);
    drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule

// File: doc/gbcore_buffered.md
# gbcore_buffered

Parametrised successor of the 8-bit Game-Boy-style register/ALU core, with a configurable datapath width. Instructions arrive through a valid/ready handshake into an internal instruction FIFO. They retire one per cycle against an internal 8-entry register file with flags. New behaviour: HALT/resume control and a retired-instruction counter. It sits between the instruction source (testbench driver or fetch unit) and the probe-based checker.

## Interface
- DATA_W, 8: register/data width; must be >= 8; flags occupy F[DATA_W-1:DATA_W-4].
- FIFO_DEPTH, 4: instruction FIFO entries; power of two, >= 2.
- CNT_W, 16: width of the retired counter.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instruction  in  8  opcode.
- data  in  DATA_W  immediate operand for LD r,d.
- in_valid  in  1  instruction/data valid.
- in_ready  out  1  FIFO can accept.
- resume  in  1  leave HALT state.
- probe  out  8*DATA_W  {A,B,C,D,E,F,H,L}.
- halted  out  1  core in HALT state.
- retired  out  CNT_W  count of executed instructions, wraps.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held.

## Operation
- Reset values: A=0, B=1, C=2, D=3, E=4, F=0, H=5, L=6.
- Reset also forces FIFO empty, halted=0, retired=0 and fifo_level=0.
- in_ready=0 while reset is asserted.
- Register index: 0=B, 1=C, 2=D, 3=E, 4=H, 5=L, 6=none, 7=A. As a source, index 6 reads 0; as a destination, index 6 writes nothing.
- Push: in_valid & in_ready at an edge stores {instruction,data}. in_ready = !full; a push is never accepted when full, even if a pop occurs in the same cycle.
- Pop/execute: each edge with !halted and FIFO non-empty, the head is executed and removed, and retired increments.
- Opcode decode:
  - 0x06,0x0E,0x16,0x1E,0x26,0x2E,0x3E: LD r[5:3] <- data.
  - 0x76: HALT; sets halted=1, no register change.
  - 0x40-0x7F except 0x76: LD r[5:3] <- r[2:0].
  - 0x80-0xBF: ALU op [5:3] on A and r[2:0]. Op order: ADD, ADC, SUB, SBC, AND, XOR, OR, CP.
  - Every other opcode: NOP (retired, no state change).
- ALU writes and flags:
  - A is written for all ops except CP.
  - F is written for all ALU ops as {Z,N,H,C, zeros}.
  - Z = result is zero.
  - N = 1 for SUB, SBC and CP; 0 otherwise.
  - H = carry/borrow out of bit 3.
  - C = carry/borrow out of bit DATA_W-1.
  - ADC and SBC include the old C.
  - AND gives H=1, C=0. XOR and OR give H=0, C=0.
- Arithmetic is modulo 2^DATA_W. F low bits are always 0.
- HALT state: no pops, but the FIFO still accepts pushes. resume=1 at an edge while halted clears halted. resume while not halted is ignored.

## Timing
- Push at edge N: the earliest execution is edge N+1, with no bypass. probe and retired reflect it after edge N+1.
- Throughput: one instruction per cycle.
- fifo_level updates at each edge: +1 on a push, -1 on a pop, unchanged on both or neither.
- HALT executed at edge N: halted=1 after edge N. resume sampled at edge M clears halted; the next pop occurs at edge M+1.
- Back-to-back dependent instructions see previous results; the register file is read in the execute cycle.
- Reset asserted mid-operation: all state returns to reset values immediately, and FIFO contents are discarded.
- retired wraps from 2^CNT_W-1 to 0.

## Test plan
- Reset, then ADD A,B (0x80) -> A=0x01, F=0x00, retired=1.
- LD A,d with data=0xFF (0x3E), then 0x80 -> A=0x00, F=0xB0 (Z,H,C).
- SUB A,A (0x97) from reset -> A=0x00, F=0xC0. Then CP A,B (0xB8) -> A unchanged at 0x00, F=0x70.
- HALT (0x76), then push 5 NOPs -> halted=1. in_ready drops after 4 accepted, fifo_level=4. Pulse resume -> drains over 4 cycles, retired=5.
- LD B,C (0x41) then LD H,A (0x67) then LD A,(HL) (0x7E) -> B=2, H=0, A=0. Next, LD (HL),B (0x70) -> no register change.
- DATA_W=16: LD A,d with data=0xFFFF, then ADD A,B -> A=0x0000, F=0xB000.
- Reset pulse mid-stream with 3 queued -> probe at reset values, fifo_level=0, no stale instruction executes after release.
